channel_err_inj: RTL and testbench
==================================

CHANNEL_ERR_INJ -- requirements
Module: channel_err_inj

Interface
REQ-001 Parameter W, default 2: channel symbol width in bits (1..16).
REQ-002 Parameter PERIOD_LOG2, default 3: periodic/burst trigger every 2**PERIOD_LOG2 symbols (1..8).
REQ-003 Parameter WINDOW, default 256: number of symbols per injection run (1..2**31).
REQ-004 Parameter SEED, default 16'hACE1: LFSR reset/restart value, nonzero.
REQ-005 clk  input  1: single clock, all logic on rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 start  input  1: one-cycle pulse; begins a run, latches configuration.
REQ-008 cfg_mode  input  2: 0 off, 1 periodic, 2 burst, 3 random.
REQ-009 cfg_mask  input  W: bits flipped in an injected symbol.
REQ-010 cfg_burst_len  input  4: symbols per burst (0 treated as 1).
REQ-011 cfg_thresh  input  8: random-mode injection threshold.
REQ-012 valid_i  input  1: data_i carries a symbol this cycle.
REQ-013 data_i  input  W: clean encoder symbol.
REQ-014 valid_o  output  1: data_o carries a symbol.
REQ-015 data_o  output  W: possibly corrupted symbol.
REQ-016 err_o  output  1: data_o was corrupted (mask applied) this symbol.
REQ-017 busy  output  1: high in RUN or BURST.
REQ-018 sym_ct, inj_ct, bit_err_ct  output  32 each: symbols seen, symbols corrupted, bits flipped in current/last run.

Function
REQ-019 States IDLE, RUN, BURST, DONE; reset enters IDLE.
REQ-020 IDLE/DONE: start -> RUN, clears all counters, reloads LFSR with SEED, latches cfg_* into internal registers; cfg_* changes during RUN/BURST have no effect.
REQ-021 start in RUN/BURST is ignored.
REQ-022 Datapath latency exactly 1 cycle: valid_o(t+1)=valid_i(t); data_o(t+1)=data_i(t)^(inj?mask:0); err_o(t+1)=inj&valid_i(t).
REQ-023 valid_i low: valid_o and err_o low next cycle, data_o holds, no counter or LFSR change.
REQ-024 In IDLE/DONE inj=0 (clean pass-through); counters frozen.
REQ-025 Accepted symbol = valid_i high in RUN/BURST; each increments sym_ct; index k = sym_ct value before increment.
REQ-026 Periodic: inj when k[PERIOD_LOG2-1:0] all ones.
REQ-027 Burst: at periodic trigger, inj and enter BURST; inj on that and next burst_len-1 accepted symbols, then return to RUN; triggers inside a burst ignored.
REQ-028 Random: 16-bit Galois LFSR taps 0xB400 advances once per accepted symbol; inj when current lfsr[7:0] < thresh; thresh 0 never injects.
REQ-029 Mode 0: no injection, symbols still counted.
REQ-030 Accepted symbol with k = WINDOW-1 is last of run: next state DONE regardless of burst progress (burst truncated).
REQ-031 inj_ct += 1 per injected symbol; bit_err_ct += popcount(mask) per injected symbol.
REQ-032 All counters saturate at 32'hFFFF_FFFF, never wrap.
REQ-033 busy high exactly in RUN and BURST.

Reset
REQ-034 rst high on any edge, including mid-run/mid-burst: state IDLE, valid_o=0, err_o=0, data_o=0, busy=0, all counters 0, LFSR=SEED, latched cfg = 0; rst overrides simultaneous start.

Configuration
REQ-035 Macro CHANNEL_ERR_INJ_STATS_EN defined: bit_err_ct implemented per REQ-031.
REQ-036 Macro undefined: bit_err_ct tied to 0, no popcount logic; all other behaviour identical.

Verification
REQ-037 W=2, mode 1, mask 2'b10, PERIOD_LOG2=3, WINDOW=256, continuous valid -> err_o on symbols 7,15,...,255; inj_ct=32, bit_err_ct=32, DONE after 256.
REQ-038 Mode 2, burst_len 3 -> err_o on symbols 7,8,9,15,16,17,...; burst_len 0 behaves as 1.
REQ-039 Mode 3, thresh 0 -> inj_ct=0 after 256 symbols; thresh 255 matches bench LFSR model symbol-by-symbol.
REQ-040 valid_i toggled 50% in mode 1 -> injection positions follow accepted-symbol index, not cycle count; latency 1 cycle.
REQ-041 rst asserted mid-burst with start same cycle -> IDLE, counters 0, next start restarts cleanly.
REQ-042 Mask 2'b11 with STATS_EN undefined -> bit_err_ct=0; defined -> bit_err_ct = 2*inj_ct.

Source files
------------

// File: rtl/channel_err_inj.sv
// Channel error injector: passes encoder symbols through with one cycle latency and
// flips cfg_mask bits on selected symbols. Per-bit statistics need CHANNEL_ERR_INJ_STATS_EN.
module channel_err_inj #(
    parameter int              W           = 2,
    parameter int              PERIOD_LOG2 = 3,
    parameter longint unsigned WINDOW      = 256,
    parameter logic [15:0]     SEED        = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   cfg_mode,
    input  logic [W-1:0] cfg_mask,
    input  logic [3:0]   cfg_burst_len,
    input  logic [7:0]   cfg_thresh,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         err_o,
    output logic         busy,
    output logic [31:0]  sym_ct,
    output logic [31:0]  inj_ct,
    output logic [31:0]  bit_err_ct
);

    // state | meaning
    // IDLE  | waiting for start, clean pass-through
    // RUN   | counting symbols, injecting per mode
    // BURST | injecting every accepted symbol until burst_rem runs out
    // DONE  | window finished, clean pass-through, counters hold results
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BURST, S_DONE} state_t;

    localparam logic [1:0]  M_PERIODIC = 2'd1;
    localparam logic [1:0]  M_BURST    = 2'd2;
    localparam logic [1:0]  M_RANDOM   = 2'd3;
    localparam logic [31:0] WIN_LAST   = 32'(WINDOW - 64'd1);

    state_t       state, state_nx;
    logic [1:0]   mode_q;
    logic [W-1:0] mask_q;
    logic [3:0]   blen_q;
    logic [7:0]   thresh_q;
    logic [15:0]  lfsr;
    logic [3:0]   burst_rem, burst_rem_nx;
    logic         accept, trig, inj, load, last_sym;

    assign busy     = (state == S_RUN) || (state == S_BURST);
    assign accept   = valid_i && busy;
    assign load     = start && !busy;
    assign trig     = &sym_ct[PERIOD_LOG2-1:0];
    assign last_sym = (sym_ct == WIN_LAST);

    always_comb begin
        state_nx     = state;
        burst_rem_nx = burst_rem;
        inj          = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    case (mode_q)
                        M_PERIODIC: inj = trig;
                        M_BURST: begin
                            if (trig) begin
                                inj = 1'b1;
                                // burst_len 0 or 1 is a single symbol, no BURST visit
                                if (blen_q > 4'd1) begin
                                    state_nx     = S_BURST;
                                    burst_rem_nx = blen_q - 4'd1;
                                end
                            end
                        end
                        M_RANDOM: inj = (lfsr[7:0] < thresh_q);
                        default: inj = 1'b0;
                    endcase
                    if (last_sym) state_nx = S_DONE;
                end
            end
            S_BURST: begin
                if (accept) begin
                    inj          = 1'b1;
                    burst_rem_nx = burst_rem - 4'd1;
                    if (burst_rem == 4'd1) state_nx = S_RUN;
                    if (last_sym) state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            burst_rem <= '0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            data_o    <= '0;
            sym_ct    <= '0;
            inj_ct    <= '0;
            lfsr      <= SEED;
            mode_q    <= '0;
            mask_q    <= '0;
            blen_q    <= '0;
            thresh_q  <= '0;
        end else begin
            state     <= state_nx;
            burst_rem <= burst_rem_nx;
            valid_o   <= valid_i;
            err_o     <= inj && valid_i;
            if (valid_i) data_o <= data_i ^ (inj ? mask_q : '0);
            if (load) begin
                sym_ct   <= '0;
                inj_ct   <= '0;
                lfsr     <= SEED;
                mode_q   <= cfg_mode;
                mask_q   <= cfg_mask;
                blen_q   <= cfg_burst_len;
                thresh_q <= cfg_thresh;
            end else if (accept) begin
                if (sym_ct != '1) sym_ct <= sym_ct + 32'd1;
                if (inj && inj_ct != '1) inj_ct <= inj_ct + 32'd1;
                lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            end
        end
    end

`ifdef CHANNEL_ERR_INJ_STATS_EN
    logic [5:0]  mask_pop;
    logic [32:0] bit_err_sum;

    always_comb begin
        mask_pop = '0;
        for (int i = 0; i < W; i++) mask_pop = mask_pop + 6'(mask_q[i]);
    end

    assign bit_err_sum = {1'b0, bit_err_ct} + 33'(mask_pop);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            bit_err_ct <= '0;
        end else if (accept && inj) begin
            bit_err_ct <= bit_err_sum[32] ? 32'hFFFF_FFFF : bit_err_sum[31:0];
        end
    end
`else
    assign bit_err_ct = '0;
`endif

endmodule

// File: tb/tb_channel_err_inj.sv
// Randomized bench for channel_err_inj: a symbol-index reference model predicts
// every output symbol and the end-of-run counters.
module tb_channel_err_inj;

    localparam int          W      = 2;
    localparam int          PLOG   = 3;
    localparam int          PER    = 1 << PLOG;
    localparam int          WINDOW = 256;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst, start, valid_i;
    logic [1:0]   cfg_mode;
    logic [W-1:0] cfg_mask, data_i;
    logic [3:0]   cfg_burst_len;
    logic [7:0]   cfg_thresh;
    logic         valid_o, err_o, busy;
    logic [W-1:0] data_o;
    logic [31:0]  sym_ct, inj_ct, bit_err_ct;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_data = '0;

    channel_err_inj #(.W(W), .PERIOD_LOG2(PLOG), .WINDOW(WINDOW), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
        .cfg_burst_len(cfg_burst_len), .cfg_thresh(cfg_thresh), .valid_i(valid_i),
        .data_i(data_i), .valid_o(valid_o), .data_o(data_o), .err_o(err_o), .busy(busy),
        .sym_ct(sym_ct), .inj_ct(inj_ct), .bit_err_ct(bit_err_ct)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic lsb;
        lsb = x[0];
        x   = x >> 1;
        if (lsb) x = x ^ 16'hB400;
        return x;
    endfunction

    function automatic int ones(input logic [W-1:0] m);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(m[i]);
        return n;
    endfunction

    // Runs one full window; expected injection comes from the symbol index k alone.
    task automatic run_window(input logic [1:0] mode, input logic [W-1:0] mask,
                              input logic [3:0] blen, input logic [7:0] thresh,
                              input int vprob, input string tag);
        int           k = 0, cyc = 0, burst_end = -1, len, n_inj = 0;
        logic [15:0]  lf = SEED;
        logic         v, inj;
        logic [W-1:0] d;
        len = (blen == 0) ? 1 : int'(blen);
        start = 1'b1; valid_i = 1'b0;
        cfg_mode = mode; cfg_mask = mask; cfg_burst_len = blen; cfg_thresh = thresh;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || sym_ct !== 32'd0 || inj_ct !== 32'd0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s start: busy=%b sym=%0d inj=%0d vo=%b, need busy=1 sym=0 inj=0 vo=0",
                     tag, busy, sym_ct, inj_ct, valid_o);
        end
        while (k < WINDOW && cyc < 8 * WINDOW + 100) begin
            v = ($urandom_range(99) < vprob);
            d = W'($urandom);
            cfg_mode = 2'($urandom); cfg_mask = W'($urandom);
            cfg_burst_len = 4'($urandom); cfg_thresh = 8'($urandom);
            start = ($urandom_range(19) == 0);
            inj = 1'b0;
            if (v) begin
                case (mode)
                    2'd1: inj = (k % PER == PER - 1);
                    2'd2: begin
                        if (k <= burst_end) inj = 1'b1;
                        else if (k % PER == PER - 1) begin
                            inj = 1'b1;
                            burst_end = k + len - 1;
                        end
                    end
                    2'd3: inj = (lf[7:0] < thresh);
                    default: inj = 1'b0;
                endcase
                lf = lfsr_step(lf);
                if (inj) n_inj++;
                k++;
                exp_data = d ^ (inj ? mask : '0);
            end
            valid_i = v; data_i = d;
            @(posedge clk); #1;
            cyc++;
            checks++;
            if (valid_o !== v || err_o !== inj || data_o !== exp_data) begin
                errors++;
                $display("FAIL %s sym k=%0d: vo=%b err=%b data=%h, need vo=%b err=%b data=%h",
                         tag, k, valid_o, err_o, data_o, v, inj, exp_data);
            end
            checks++;
            if (busy !== (k < WINDOW)) begin
                errors++;
                $display("FAIL %s busy k=%0d: got %b need %b", tag, k, busy, k < WINDOW);
            end
        end
        start = 1'b0; valid_i = 1'b0;
        if (k < WINDOW) begin
            errors++;
            $display("FAIL %s timeout: accepted %0d need %0d", tag, k, WINDOW);
        end
        checks++;
        if (sym_ct !== 32'(WINDOW) || inj_ct !== 32'(n_inj)) begin
            errors++;
            $display("FAIL %s counts: sym=%0d inj=%0d need sym=%0d inj=%0d",
                     tag, sym_ct, inj_ct, WINDOW, n_inj);
        end
        checks++;
`ifdef CHANNEL_ERR_INJ_STATS_EN
        if (bit_err_ct !== 32'(n_inj * ones(mask))) begin
            errors++;
            $display("FAIL %s bit_err: got %0d need %0d", tag, bit_err_ct, n_inj * ones(mask));
        end
`else
        if (bit_err_ct !== 32'd0) begin
            errors++;
            $display("FAIL %s bit_err: got %0d need 0", tag, bit_err_ct);
        end
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; valid_i = 1'b0; data_i = '0;
        cfg_mode = '0; cfg_mask = '0; cfg_burst_len = '0; cfg_thresh = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b0 || err_o !== 1'b0 || data_o !== '0 || busy !== 1'b0 ||
            sym_ct !== 0 || inj_ct !== 0 || bit_err_ct !== 0) begin
            errors++;
            $display("FAIL reset: vo=%b err=%b data=%h busy=%b sym=%0d inj=%0d bit=%0d, need all 0",
                     valid_o, err_o, data_o, busy, sym_ct, inj_ct, bit_err_ct);
        end
        rst = 1'b0;
        exp_data = '0;
        valid_i = 1'b1; data_i = 2'b01; cfg_mode = 2'd1; cfg_mask = '1;
        @(posedge clk); #1;
        exp_data = 2'b01;
        valid_i = 1'b0;
        checks++;
        if (data_o !== 2'b01 || err_o !== 1'b0 || sym_ct !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_pass: data=%h err=%b sym=%0d busy=%b, need 1 0 0 0",
                     data_o, err_o, sym_ct, busy);
        end
    endtask

    task automatic test_periodic;
        run_window(2'd1, 2'b10, 4'd0, 8'd0, 100, "periodic");
        checks++;
        if (inj_ct !== 32'd32) begin
            errors++;
            $display("FAIL periodic_total: inj_ct=%0d need 32", inj_ct);
        end
    endtask

    task automatic test_done_passthrough;
        logic [W-1:0] d;
        for (int i = 0; i < 6; i++) begin
            d = W'($urandom);
            valid_i = 1'b1; data_i = d; cfg_mode = 2'd1; cfg_mask = '1;
            start = 1'b0;
            @(posedge clk); #1;
            exp_data = d;
            checks++;
            if (data_o !== d || err_o !== 1'b0 || busy !== 1'b0 || sym_ct !== 32'(WINDOW)) begin
                errors++;
                $display("FAIL done_pass: data=%h err=%b busy=%b sym=%0d, need data=%h err=0 busy=0 sym=%0d",
                         data_o, err_o, busy, sym_ct, d, WINDOW);
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_burst;
        run_window(2'd2, 2'b01, 4'd3, 8'd0, 100, "burst3");
        checks++;
        if (inj_ct !== 32'd94) begin
            errors++;
            $display("FAIL burst3_total: inj_ct=%0d need 94", inj_ct);
        end
        run_window(2'd2, 2'b10, 4'd0, 8'd0, 100, "burst0");
        checks++;
        if (inj_ct !== 32'd32) begin
            errors++;
            $display("FAIL burst0_total: inj_ct=%0d need 32", inj_ct);
        end
        for (int i = 0; i < 3; i++)
            run_window(2'd2, W'($urandom), 4'($urandom_range(15, 1)), 8'd0, 70, "burst_rand");
    endtask

    task automatic test_random;
        run_window(2'd3, 2'b11, 4'd0, 8'd0, 100, "rand_t0");
        checks++;
        if (inj_ct !== 32'd0) begin
            errors++;
            $display("FAIL rand_t0_total: inj_ct=%0d need 0", inj_ct);
        end
        run_window(2'd3, 2'b01, 4'd0, 8'd255, 100, "rand_t255");
        run_window(2'd3, 2'b10, 4'd0, 8'($urandom_range(200, 40)), 60, "rand_mid");
    endtask

    task automatic test_valid_gaps;
        run_window(2'd1, 2'b01, 4'd0, 8'd0, 50, "gaps");
        checks++;
        if (inj_ct !== 32'd32) begin
            errors++;
            $display("FAIL gaps_total: inj_ct=%0d need 32", inj_ct);
        end
    endtask

    task automatic test_mode_off;
        run_window(2'd0, 2'b11, 4'd5, 8'd255, 80, "off");
        checks++;
        if (inj_ct !== 32'd0) begin
            errors++;
            $display("FAIL off_total: inj_ct=%0d need 0", inj_ct);
        end
    endtask

    task automatic test_mask_stats;
        run_window(2'd1, 2'b11, 4'd0, 8'd0, 100, "mask11");
        checks++;
`ifdef CHANNEL_ERR_INJ_STATS_EN
        if (bit_err_ct !== 32'd64) begin
            errors++;
            $display("FAIL mask11_bits: bit_err_ct=%0d need 64", bit_err_ct);
        end
`else
        if (bit_err_ct !== 32'd0 || inj_ct !== 32'd32) begin
            errors++;
            $display("FAIL mask11_bits: bit_err_ct=%0d inj_ct=%0d need 0 and 32", bit_err_ct, inj_ct);
        end
`endif
    endtask

    task automatic test_reset_mid_burst;
        start = 1'b1; valid_i = 1'b0;
        cfg_mode = 2'd2; cfg_mask = 2'b11; cfg_burst_len = 4'd15; cfg_thresh = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            valid_i = 1'b1; data_i = W'($urandom);
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1 || err_o !== 1'b1 || sym_ct !== 32'd10 || inj_ct !== 32'd3) begin
            errors++;
            $display("FAIL midburst_pre: busy=%b err=%b sym=%0d inj=%0d, need 1 1 10 3",
                     busy, err_o, sym_ct, inj_ct);
        end
        rst = 1'b1; start = 1'b1; valid_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0 || err_o !== 1'b0 || data_o !== '0 ||
            sym_ct !== 0 || inj_ct !== 0 || bit_err_ct !== 0) begin
            errors++;
            $display("FAIL midburst_rst: busy=%b vo=%b err=%b data=%h sym=%0d inj=%0d bit=%0d, need all 0",
                     busy, valid_o, err_o, data_o, sym_ct, inj_ct, bit_err_ct);
        end
        rst = 1'b0; start = 1'b0; valid_i = 1'b0;
        exp_data = '0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midburst_idle: busy=%b need 0", busy);
        end
        run_window(2'd2, 2'b01, 4'd3, 8'd0, 100, "restart");
        checks++;
        if (inj_ct !== 32'd94) begin
            errors++;
            $display("FAIL restart_total: inj_ct=%0d need 94", inj_ct);
        end
    endtask

    initial begin
        test_reset;
        test_periodic;
        test_done_passthrough;
        test_burst;
        test_random;
        test_valid_gaps;
        test_mode_off;
        test_mask_stats;
        test_reset_mid_burst;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
